// File: rtl/count_mon_pkg.sv
// Shared types and constants for the count_monitor block: FSM states,
// the Gray-to-binary helper and active-low seven-segment digit patterns.
package count_mon_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Segment patterns are active-low, bit order gfedcba
  localparam logic [6:0] SEG7_0 = 7'b1000000;
  localparam logic [6:0] SEG7_1 = 7'b1111001;
  localparam logic [6:0] SEG7_2 = 7'b0100100;
  localparam logic [6:0] SEG7_3 = 7'b0110000;
  localparam logic [6:0] SEG7_4 = 7'b0011001;
  localparam logic [6:0] SEG7_5 = 7'b0010010;
  localparam logic [6:0] SEG7_6 = 7'b0000010;
  localparam logic [6:0] SEG7_7 = 7'b1111000;
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

endpackage

// File: rtl/count_monitor_if.sv
// Bundle between the counter under observation and count_monitor.
// The seg field only exists when COUNT_MON_SEG7_EN is defined.
interface count_monitor_if #(parameter int CNT_W = 8);

  logic [2:0]       q;
  logic             m;
  logic             clr;
  logic [2:0]       bin;
  logic             up_p;
  logic             dn_p;
  logic             wrap_p;
  logic             err_p;
  logic             fault;
  logic [CNT_W-1:0] err_cnt;
`ifdef COUNT_MON_SEG7_EN
  logic [6:0]       seg;

  modport master (output q, m, clr,
                  input  bin, up_p, dn_p, wrap_p, err_p, fault, err_cnt, seg);
  modport slave  (input  q, m, clr,
                  output bin, up_p, dn_p, wrap_p, err_p, fault, err_cnt, seg);
`else
  modport master (output q, m, clr,
                  input  bin, up_p, dn_p, wrap_p, err_p, fault, err_cnt);
  modport slave  (input  q, m, clr,
                  output bin, up_p, dn_p, wrap_p, err_p, fault, err_cnt);
`endif

endinterface

// File: rtl/count_monitor_seg7_dec.sv
// seg7_dec: combinational 3-bit value to active-low gfedcba segments.
module seg7_dec
  import count_mon_pkg::*;
(
  input  logic [2:0] val,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG7_BLANK;
    case (val)
      3'd0: seg = SEG7_0;
      3'd1: seg = SEG7_1;
      3'd2: seg = SEG7_2;
      3'd3: seg = SEG7_3;
      3'd4: seg = SEG7_4;
      3'd5: seg = SEG7_5;
      3'd6: seg = SEG7_6;
      3'd7: seg = SEG7_7;
      default: seg = SEG7_BLANK;
    endcase
  end

endmodule

// File: rtl/count_monitor.sv
// count_monitor: classifies each change of a 3-bit binary/Gray counter as +1, -1
// or illegal. Define COUNT_MON_SEG7_EN to add the registered seven-segment output.
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
)
(
  input  logic             clk,
  input  logic             rst,
  count_monitor_if.slave   bus
);

  state_t           state, state_nxt;
  logic [2:0]       v, prev_v, bin_r;
  logic             prev_m;
  logic             up_r, dn_r, wrap_r, err_r;
  logic             up_nxt, dn_nxt, wrap_nxt, err_nxt;
  logic [CNT_W-1:0] err_cnt_r, err_cnt_nxt;

  assign v = bus.m ? gray2bin(bus.q) : bus.q;

  // A mode change only re-seeds the reference; it is never judged as a step
  always_comb begin
    state_nxt   = state;
    up_nxt      = 1'b0;
    dn_nxt      = 1'b0;
    wrap_nxt    = 1'b0;
    err_nxt     = 1'b0;
    err_cnt_nxt = err_cnt_r;
    case (state)
      EMPTY: state_nxt = TRACK;
      TRACK, FAULT: begin
        if (bus.m == prev_m && v != prev_v) begin
          if (v == prev_v + 3'd1) begin
            up_nxt   = 1'b1;
            wrap_nxt = (prev_v == 3'd7);
          end else if (v == prev_v - 3'd1) begin
            dn_nxt   = 1'b1;
            wrap_nxt = (prev_v == 3'd0);
          end else begin
            err_nxt   = 1'b1;
            state_nxt = FAULT;
            if (err_cnt_r != '1) err_cnt_nxt = err_cnt_r + CNT_W'(1);
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      state     <= EMPTY;
      prev_v    <= 3'd0;
      prev_m    <= 1'b0;
      bin_r     <= 3'd0;
      up_r      <= 1'b0;
      dn_r      <= 1'b0;
      wrap_r    <= 1'b0;
      err_r     <= 1'b0;
      err_cnt_r <= '0;
    end else begin
      state     <= state_nxt;
      prev_v    <= v;
      prev_m    <= bus.m;
      bin_r     <= v;
      up_r      <= up_nxt;
      dn_r      <= dn_nxt;
      wrap_r    <= wrap_nxt;
      err_r     <= err_nxt;
      err_cnt_r <= err_cnt_nxt;
    end
  end

  assign bus.bin     = bin_r;
  assign bus.up_p    = up_r;
  assign bus.dn_p    = dn_r;
  assign bus.wrap_p  = wrap_r;
  assign bus.err_p   = err_r;
  assign bus.fault   = (state == FAULT);
  assign bus.err_cnt = err_cnt_r;

`ifdef COUNT_MON_SEG7_EN
  logic [6:0] seg_nxt, seg_r;

  seg7_dec u_seg7_dec (
    .val (v),
    .seg (seg_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.clr) seg_r <= SEG7_BLANK;
    else                seg_r <= seg_nxt;
  end

  assign bus.seg = seg_r;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: one default-width instance and one with a
// 2-bit error counter share the same stimulus so saturation can be observed.
module tb_count_monitor;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_UP   = 4'b1000;
  localparam logic [3:0] P_DN   = 4'b0100;
  localparam logic [3:0] P_UPW  = 4'b1010;
  localparam logic [3:0] P_DNW  = 4'b0110;
  localparam logic [3:0] P_ERR  = 4'b0001;

  count_monitor_if #(.CNT_W(8)) bus8 ();
  count_monitor_if #(.CNT_W(2)) bus2 ();

  count_monitor #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  count_monitor #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] qv, input logic mv,
                               input logic clrv, input logic rstv);
    @(negedge clk);
    rst      = rstv;
    bus8.q   = qv;
    bus8.m   = mv;
    bus8.clr = clrv;
    bus2.q   = qv;
    bus2.m   = mv;
    bus2.clr = clrv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [2:0] eb,
                            input logic [3:0] ep, input logic ef,
                            input logic [7:0] e8, input logic [1:0] e2);
    checkOutput({tag, ".bin"}, 32'(bus8.bin), 32'(eb));
    checkOutput({tag, ".pulses8"},
                32'({bus8.up_p, bus8.dn_p, bus8.wrap_p, bus8.err_p}), 32'(ep));
    checkOutput({tag, ".pulses2"},
                32'({bus2.up_p, bus2.dn_p, bus2.wrap_p, bus2.err_p}), 32'(ep));
    checkOutput({tag, ".fault"}, 32'(bus8.fault), 32'(ef));
    checkOutput({tag, ".cnt8"}, 32'(bus8.err_cnt), 32'(e8));
    checkOutput({tag, ".cnt2"}, 32'(bus2.err_cnt), 32'(e2));
  endtask

  logic [2:0] grayDown [8];
  logic [2:0] jumpSeq  [4];

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    bus8.q = 3'd0; bus8.m = 1'b0; bus8.clr = 1'b0;
    bus2.q = 3'd0; bus2.m = 1'b0; bus2.clr = 1'b0;
    grayDown = '{3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000};
    jumpSeq  = '{3'd7, 3'd2, 3'd5, 3'd0};

    $display("[TB] reset and binary ramp");
    applyStimulus(3'd5, 1'b0, 1'b0, 1'b1);
    checkState("reset", 3'd0, P_NONE, 1'b0, 8'd0, 2'd0);
`ifdef COUNT_MON_SEG7_EN
    checkOutput("reset.seg", 32'(bus8.seg), 32'(7'b1111111));
`endif
    applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
    checkState("seed0", 3'd0, P_NONE, 1'b0, 8'd0, 2'd0);
`ifdef COUNT_MON_SEG7_EN
    checkOutput("seed0.seg", 32'(bus8.seg), 32'(7'b1000000));
`endif
    for (int i = 1; i < 8; i++) begin
      applyStimulus(3'(i), 1'b0, 1'b0, 1'b0);
      checkState($sformatf("ramp%0d", i), 3'(i), P_UP, 1'b0, 8'd0, 2'd0);
    end
`ifdef COUNT_MON_SEG7_EN
    checkOutput("ramp7.seg", 32'(bus8.seg), 32'(7'b1111000));
`endif
    applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
    checkState("wrap_up", 3'd0, P_UPW, 1'b0, 8'd0, 2'd0);
    applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
    checkState("hold", 3'd0, P_NONE, 1'b0, 8'd0, 2'd0);

    $display("[TB] Gray walk downward");
    applyStimulus(3'd0, 1'b1, 1'b0, 1'b0);
    checkState("to_gray", 3'd0, P_NONE, 1'b0, 8'd0, 2'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(grayDown[i], 1'b1, 1'b0, 1'b0);
      checkState($sformatf("gray%0d", i), 3'(7 - i), (i == 0) ? P_DNW : P_DN,
                 1'b0, 8'd0, 2'd0);
    end

    $display("[TB] illegal jump and sticky fault");
    applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
    checkState("to_bin", 3'd0, P_NONE, 1'b0, 8'd0, 2'd0);
    applyStimulus(3'd1, 1'b0, 1'b0, 1'b0);
    checkState("up1", 3'd1, P_UP, 1'b0, 8'd0, 2'd0);
    applyStimulus(3'd2, 1'b0, 1'b0, 1'b0);
    checkState("up2", 3'd2, P_UP, 1'b0, 8'd0, 2'd0);
    applyStimulus(3'd5, 1'b0, 1'b0, 1'b0);
    checkState("jump2to5", 3'd5, P_ERR, 1'b1, 8'd1, 2'd1);
    applyStimulus(3'd6, 1'b0, 1'b0, 1'b0);
    checkState("up_in_fault", 3'd6, P_UP, 1'b1, 8'd1, 2'd1);
    applyStimulus(3'd6, 1'b0, 1'b0, 1'b0);
    checkState("hold_fault", 3'd6, P_NONE, 1'b1, 8'd1, 2'd1);

    $display("[TB] clear and mode toggle on fixed q");
    applyStimulus(3'd3, 1'b0, 1'b1, 1'b0);
    checkState("clr1", 3'd0, P_NONE, 1'b0, 8'd0, 2'd0);
    applyStimulus(3'd3, 1'b0, 1'b0, 1'b0);
    checkState("seed3", 3'd3, P_NONE, 1'b0, 8'd0, 2'd0);
    applyStimulus(3'd3, 1'b1, 1'b0, 1'b0);
    checkState("mode_to_gray", 3'd2, P_NONE, 1'b0, 8'd0, 2'd0);
    applyStimulus(3'd3, 1'b0, 1'b0, 1'b0);
    checkState("mode_to_bin", 3'd3, P_NONE, 1'b0, 8'd0, 2'd0);

    $display("[TB] error counter saturation");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(jumpSeq[i], 1'b0, 1'b0, 1'b0);
      checkState($sformatf("jump%0d", i), jumpSeq[i], P_ERR, 1'b1,
                 8'(i + 1), (i < 3) ? 2'(i + 1) : 2'd3);
    end
    applyStimulus(3'd4, 1'b0, 1'b1, 1'b0);
    checkState("clr_beats_err", 3'd0, P_NONE, 1'b0, 8'd0, 2'd0);
    applyStimulus(3'd4, 1'b0, 1'b0, 1'b0);
    checkState("seed4", 3'd4, P_NONE, 1'b0, 8'd0, 2'd0);
    applyStimulus(3'd5, 1'b0, 1'b0, 1'b0);
    checkState("up5", 3'd5, P_UP, 1'b0, 8'd0, 2'd0);

    $display("[TB] mid-run reset and binary down wrap");
    applyStimulus(3'd5, 1'b0, 1'b0, 1'b1);
    checkState("rst_mid", 3'd0, P_NONE, 1'b0, 8'd0, 2'd0);
    applyStimulus(3'd2, 1'b0, 1'b0, 1'b0);
    checkState("reseed2", 3'd2, P_NONE, 1'b0, 8'd0, 2'd0);
    applyStimulus(3'd1, 1'b0, 1'b0, 1'b0);
    checkState("dn1", 3'd1, P_DN, 1'b0, 8'd0, 2'd0);
    applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
    checkState("dn0", 3'd0, P_DN, 1'b0, 8'd0, 2'd0);
    applyStimulus(3'd7, 1'b0, 1'b0, 1'b0);
    checkState("wrap_dn", 3'd7, P_DNW, 1'b0, 8'd0, 2'd0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
